huffman_encoder_serial: RTL and testbench

Upstream companion of the serial Huffman decoder. Accepts symbol indices 1..18 over a valid/ready handshake and buffers them in a small FIFO. Serialises each symbol's fixed prefix code MSB-first, one bit per clock, with no gaps between consecutive codes, to drive the decoder's 1-bit input.

---
 rtl/huffman_encoder_serial.sv | 167 ++++++++++++++++
 tb/tb_huffman_encoder_serial.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/huffman_encoder_serial.sv
// Serial prefix-code encoder: a symbol FIFO feeds a shifter that streams codes MSB-first, back-to-back.
// Define HUFF_ENC_STATS_EN to add the sym_count/bit_count statistics ports.
module huffman_encoder_serial #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  sym_in,
  input  logic        sym_valid,
  output logic        sym_ready,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        bit_last,
  output logic        err
`ifdef HUFF_ENC_STATS_EN
  ,
  output logic [15:0] sym_count,
  output logic [15:0] bit_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  typedef struct packed {
    logic [7:0] code;
    logic [3:0] len;
  } code_t;

  // Codes are left-aligned so the shifter always emits bit 7.
  function automatic code_t lookup(input logic [4:0] s);
    code_t c;
    case (s)
      5'd1:    c = '{8'b0000_0000, 4'd2};
      5'd2:    c = '{8'b0100_0000, 4'd2};
      5'd3:    c = '{8'b1000_0000, 4'd2};
      5'd4:    c = '{8'b1100_0000, 4'd3};
      5'd5:    c = '{8'b1110_0000, 4'd6};
      5'd6:    c = '{8'b1110_0100, 4'd6};
      5'd7:    c = '{8'b1110_1000, 4'd6};
      5'd8:    c = '{8'b1110_1100, 4'd7};
      5'd9:    c = '{8'b1110_1110, 4'd7};
      5'd10:   c = '{8'b1111_0000, 4'd7};
      5'd11:   c = '{8'b1111_0010, 4'd7};
      5'd12:   c = '{8'b1111_0100, 4'd7};
      5'd13:   c = '{8'b1111_0110, 4'd7};
      5'd14:   c = '{8'b1111_1000, 4'd7};
      5'd15:   c = '{8'b1111_1010, 4'd7};
      5'd16:   c = '{8'b1111_1100, 4'd7};
      5'd17:   c = '{8'b1111_1110, 4'd8};
      5'd18:   c = '{8'b1111_1111, 4'd8};
      default: c = '{8'b0000_0000, 4'd0};
    endcase
    return c;
  endfunction

  logic [DEPTH-1:0][4:0] mem_q, mem_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [0:0]            state_q, state_d;
  logic [7:0]            shift_q, shift_d;
  logic [3:0]            remain_q, remain_d;
  logic                  err_q, err_d;

  logic  acc, in_range, push, load;
  code_t head;

  always_comb begin
    acc      = sym_valid && sym_ready;
    in_range = (sym_in != 6'd0) && (sym_in <= 6'd18);
    push     = acc && in_range;
    // A new code loads from IDLE, or on the last bit of the current one for zero-bubble chaining.
    load     = (count_q != '0) &&
               ((state_q == IDLE) || ((state_q == SHIFT) && (remain_q == 4'd1)));
    head     = lookup(mem_q[rd_ptr_q]);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = sym_in[4:0];
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (load) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, load})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    state_d  = state_q;
    shift_d  = shift_q;
    remain_d = remain_q;
    if (load) begin
      state_d  = SHIFT;
      shift_d  = head.code;
      remain_d = head.len;
    end else if (state_q == SHIFT) begin
      if (remain_q == 4'd1) begin
        state_d  = IDLE;
        shift_d  = '0;
        remain_d = '0;
      end else begin
        shift_d  = {shift_q[6:0], 1'b0};
        remain_d = remain_q - 4'd1;
      end
    end

    err_d = acc && !in_range;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      shift_q  <= '0;
      remain_q <= '0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      remain_q <= remain_d;
      err_q    <= err_d;
    end
  end

  assign sym_ready = (count_q != FULL_CNT);
  assign bit_valid = (state_q == SHIFT);
  assign bit_out   = bit_valid && shift_q[7];
  assign bit_last  = bit_valid && (remain_q == 4'd1);
  assign err       = err_q;

`ifdef HUFF_ENC_STATS_EN
  logic [15:0] sym_count_q, sym_count_d, bit_count_q, bit_count_d;

  always_comb begin
    sym_count_d = load      ? sym_count_q + 16'd1 : sym_count_q;
    bit_count_d = bit_valid ? bit_count_q + 16'd1 : bit_count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      sym_count_q <= sym_count_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign sym_count = sym_count_q;
  assign bit_count = bit_count_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_huffman_encoder_serial.sv
// Scoreboard bench for huffman_encoder_serial: expected code bits are queued at accept and popped per valid bit.
module tb_huffman_encoder_serial;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] sym_in = '0;
  logic       sym_valid = 1'b0;
  logic       sym_ready, bit_out, bit_valid, bit_last, err;
`ifdef HUFF_ENC_STATS_EN
  logic [15:0] sym_count, bit_count;
`endif

  huffman_encoder_serial #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .bit_last(bit_last), .err(err)
`ifdef HUFF_ENC_STATS_EN
    , .sym_count(sym_count), .bit_count(bit_count)
`endif
  );

  always #5 clk = ~clk;

  // Codes right-aligned with their lengths; index 0 unused.
  int cval[19] = '{0, 0, 1, 2, 6, 56, 57, 58, 118, 119, 120, 121, 122, 123, 124, 125, 126, 254, 255};
  int clen[19] = '{0, 2, 2, 2, 3, 6, 6, 6, 7, 7, 7, 7, 7, 7, 7, 7, 7, 8, 8};

  int n_vec = 0, n_err = 0;
  int bits_seen = 0, lasts_seen = 0, runs = 0, stalls = 0;
  logic prev_valid = 1'b0;
  logic [1:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (rst) begin
      if (bit_valid) begin
        bits_seen++;
        if (bit_last) lasts_seen++;
        if (sb.size() == 0) chk("unexpected_bit", 32'(bit_valid), 0);
        else begin
          e = sb.pop_front();
          chk("bit_out", 32'(bit_out), 32'(e[1]));
          chk("bit_last", 32'(bit_last), 32'(e[0]));
        end
      end else begin
        chk("idle_zero", {30'd0, bit_out, bit_last}, 0);
      end
      if (prev_valid && !bit_valid) runs++;
      prev_valid = bit_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge, sym_valid still high.
  task automatic send(input int s);
    int n;
    sym_in = 6'(s);
    sym_valid = 1'b1;
    n = 0;
    while (!sym_ready && n < 100) begin
      stalls++;
      n++;
      @(posedge clk); #1;
    end
    if (n >= 100) chk("ready_timeout", 32'(sym_ready), 1);
    if (s >= 1 && s <= 18)
      for (int i = clen[s] - 1; i >= 0; i--)
        sb.push_back({1'((cval[s] >> i) & 1), 1'(i == 0)});
    @(posedge clk); #1;
    if (s < 1 || s > 18) chk("err_pulse", 32'(err), 1);
  endtask

  task automatic idle();
    sym_valid = 1'b0;
    sym_in = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bit_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 0);
  endtask

  // Asserts reset away from any clock edge and checks outputs before the next edge.
  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    chk("rst_bit_out", 32'(bit_out), 0);
    chk("rst_bit_valid", 32'(bit_valid), 0);
    chk("rst_bit_last", 32'(bit_last), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_sym_ready", 32'(sym_ready), 1);
    sb.delete();
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int base, rbase, lbase, n;
    #3;
    reset_pulse();

    // Single symbol 1: latency and framing.
    send(1);
    idle();
    @(negedge clk);
    chk("lat_pre", 32'(bit_valid), 0);
    @(posedge clk); #1;
    chk("lat_first", 32'(bit_valid), 1);
    @(posedge clk); #1;
    chk("single_last", {30'd0, bit_valid, bit_last}, 3);
    @(posedge clk); #1;
    chk("single_end", 32'(bit_valid), 0);
    drain();

    // Back-to-back 4, 18, 5 with no gap.
    base = bits_seen; rbase = runs; lbase = lasts_seen;
    send(4); send(18); send(5);
    idle();
    drain();
    chk("b2b_bits", 32'(bits_seen - base), 17);
    chk("b2b_runs", 32'(runs - rbase), 1);
    chk("b2b_lasts", 32'(lasts_seen - lbase), 3);

    // Six 17s with valid held: FIFO fills and backpressures.
    base = bits_seen; lbase = lasts_seen; stalls = 0;
    for (int i = 0; i < 6; i++) send(17);
    idle();
    drain();
    chk("full_stalls", 32'(stalls), 5);
    chk("full_bits", 32'(bits_seen - base), 48);
    chk("full_lasts", 32'(lasts_seen - lbase), 6);

    // Out-of-range symbols: err pulses, nothing queued.
    base = bits_seen;
    send(0);
    idle();
    @(posedge clk); #1;
    chk("err_clear0", 32'(err), 0);
    send(19);
    idle();
    @(posedge clk); #1;
    chk("err_clear19", 32'(err), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("bad_no_bits", 32'(bits_seen - base), 0);
    chk("bad_ready", 32'(sym_ready), 1);

    // Reset mid-code: 13 then 2, reset after 3 bits of 13.
    send(13); send(2);
    idle();
    base = bits_seen;
    n = 0;
    while (bits_seen < base + 3 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("mid_bits", 32'(bits_seen - base), 3);
    reset_pulse();
    base = bits_seen;
    repeat (20) @(posedge clk);
    #1;
    chk("no_resume", 32'(bits_seen - base), 0);

    // First symbol after reset encodes correctly.
    base = bits_seen;
    send(3);
    idle();
    drain();
    chk("post_rst_bits", 32'(bits_seen - base), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
